// File: rtl/sseg_mux_driver.sv
// rtl/sseg_mux_driver.sv - double-buffered multiplexed 7-segment output stage (optional macro: SSEG_GHOST_BLANK_EN)
//
// Frames arrive over a valid/ready handshake. In IDLE the first frame loads straight into
// the active buffer. Once running, a new frame parks in the pending buffer and is promoted
// only at a frame boundary, so a refresh sweep never mixes two frames.
// With SSEG_GHOST_BLANK_EN defined, the anodes are held off for the first two cycles of
// every digit slot to hide segment ghosting (REFRESH_DIV must then be at least 4).

module sseg_mux_driver #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] frame_data,
    input  logic [NUM_DIGITS-1:0]   frame_blank,
    input  logic [NUM_DIGITS-1:0]   frame_dp,
    input  logic                    frame_valid,
    output logic                    frame_ready,
    output logic                    frame_done,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              sseg
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;

    logic                    pending_full;
    logic                    pending_full_nxt;
    logic [4*NUM_DIGITS-1:0] pend_data;
    logic [4*NUM_DIGITS-1:0] pend_data_nxt;
    logic [NUM_DIGITS-1:0]   pend_blank;
    logic [NUM_DIGITS-1:0]   pend_blank_nxt;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic [NUM_DIGITS-1:0]   pend_dp_nxt;

    logic [4*NUM_DIGITS-1:0] act_data;
    logic [4*NUM_DIGITS-1:0] act_data_nxt;
    logic [NUM_DIGITS-1:0]   act_blank;
    logic [NUM_DIGITS-1:0]   act_blank_nxt;
    logic [NUM_DIGITS-1:0]   act_dp;
    logic [NUM_DIGITS-1:0]   act_dp_nxt;

    logic [PW-1:0]           prescaler;
    logic [PW-1:0]           prescaler_nxt;
    logic [IW-1:0]           idx;
    logic [IW-1:0]           idx_nxt;

    logic [NUM_DIGITS-1:0]   an_nxt;
    logic [7:0]              sseg_nxt;
    logic [3:0]              cur_nib;
    logic                    cur_blank;
    logic                    cur_dp;

    logic                    accept;
    logic                    tick;
    logic                    boundary;

    // Ready depends only on the pending flag register, never on frame_valid.
    assign frame_ready = !pending_full;
    assign accept      = frame_valid && frame_ready;
    assign tick        = (state == RUN) && (prescaler == PRE_LAST);
    assign boundary    = tick && (idx == IDX_LAST);
    assign frame_done  = boundary && !reset;

    // Hex nibble to active-low gfedcba pattern.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'b1000000;
            4'h1:    pat = 7'b1111001;
            4'h2:    pat = 7'b0100100;
            4'h3:    pat = 7'b0110000;
            4'h4:    pat = 7'b0011001;
            4'h5:    pat = 7'b0010010;
            4'h6:    pat = 7'b0000010;
            4'h7:    pat = 7'b1111000;
            4'h8:    pat = 7'b0000000;
            4'h9:    pat = 7'b0010000;
            4'hA:    pat = 7'b0001000;
            4'hB:    pat = 7'b0000011;
            4'hC:    pat = 7'b1000110;
            4'hD:    pat = 7'b0100001;
            4'hE:    pat = 7'b0000110;
            default: pat = 7'b0001110;
        endcase
        return pat;
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: the first accepted frame starts the refresh; only reset returns to IDLE.
    always_comb begin
        state_nxt = state;
        if ((state == IDLE) && accept) begin
            state_nxt = RUN;
        end
    end

    // Buffer and counter updates: IDLE loads active directly, RUN parks frames in pending
    // and promotes pending only at the frame boundary.
    always_comb begin
        pending_full_nxt = pending_full;
        pend_data_nxt    = pend_data;
        pend_blank_nxt   = pend_blank;
        pend_dp_nxt      = pend_dp;
        act_data_nxt     = act_data;
        act_blank_nxt    = act_blank;
        act_dp_nxt       = act_dp;
        prescaler_nxt    = prescaler;
        idx_nxt          = idx;
        case (state)
            IDLE: begin
                if (accept) begin
                    act_data_nxt  = frame_data;
                    act_blank_nxt = frame_blank;
                    act_dp_nxt    = frame_dp;
                    prescaler_nxt = '0;
                    idx_nxt       = '0;
                end
            end
            RUN: begin
                prescaler_nxt = tick ? '0 : prescaler + 1'b1;
                if (tick) begin
                    idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
                end
                if (boundary && pending_full) begin
                    act_data_nxt     = pend_data;
                    act_blank_nxt    = pend_blank;
                    act_dp_nxt       = pend_dp;
                    pending_full_nxt = 1'b0;
                end
                // A boundary accept can only happen with pending empty, so it never
                // collides with the promotion above; the new frame waits a full sweep.
                if (accept) begin
                    pend_data_nxt    = frame_data;
                    pend_blank_nxt   = frame_blank;
                    pend_dp_nxt      = frame_dp;
                    pending_full_nxt = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Output decode from the post-update digit index and active buffer.
    always_comb begin
        cur_nib   = 4'h0;
        cur_blank = 1'b1;
        cur_dp    = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_nxt == IW'(k)) begin
                cur_nib   = act_data_nxt[4*k +: 4];
                cur_blank = act_blank_nxt[k];
                cur_dp    = act_dp_nxt[k];
            end
        end
        an_nxt   = '1;
        sseg_nxt = 8'hFF;
        if ((state_nxt == RUN) && !cur_blank) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (idx_nxt == IW'(k)) begin
                    an_nxt[k] = 1'b0;
                end
            end
            sseg_nxt = {!cur_dp, seg_decode(cur_nib)};
        end
`ifdef SSEG_GHOST_BLANK_EN
        if ((state_nxt == RUN) && (prescaler_nxt < PW'(2))) begin
            an_nxt = '1;
        end
`endif
    end

    // Handshake buffers; reset discards both frames.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_full <= 1'b0;
            pend_data    <= '0;
            pend_blank   <= '0;
            pend_dp      <= '0;
            act_data     <= '0;
            act_blank    <= '0;
            act_dp       <= '0;
        end else begin
            pending_full <= pending_full_nxt;
            pend_data    <= pend_data_nxt;
            pend_blank   <= pend_blank_nxt;
            pend_dp      <= pend_dp_nxt;
            act_data     <= act_data_nxt;
            act_blank    <= act_blank_nxt;
            act_dp       <= act_dp_nxt;
        end
    end

    // Slot prescaler and digit index.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler <= '0;
            idx       <= '0;
        end else begin
            prescaler <= prescaler_nxt;
            idx       <= idx_nxt;
        end
    end

    // Registered anode and segment drive; dark while in reset or IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            an   <= '1;
            sseg <= 8'hFF;
        end else begin
            an   <= an_nxt;
            sseg <= sseg_nxt;
        end
    end

endmodule

// File: tb/tb_sseg_mux_driver.sv
// tb/tb_sseg_mux_driver.sv - randomized self-checking bench for sseg_mux_driver
`timescale 1ns/1ps
module tb_sseg_mux_driver;

    localparam int ND        = 8;
    localparam int RD        = 4;
    localparam int FRAME_CYC = ND * RD;
`ifdef SSEG_GHOST_BLANK_EN
    localparam bit GHOST = 1'b1;
`else
    localparam bit GHOST = 1'b0;
`endif
    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] frame_data = '0;
    logic [7:0]  frame_blank = '0;
    logic [7:0]  frame_dp = '0;
    logic        frame_valid = 1'b0;
    logic        frame_ready;
    logic        frame_done;
    logic [7:0]  an;
    logic [7:0]  sseg;

    sseg_mux_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_data  (frame_data),
        .frame_blank (frame_blank),
        .frame_dp    (frame_dp),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_done  (frame_done),
        .an          (an),
        .sseg        (sseg)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: time since the current frame began decides the digit shown.
    bit          started = 1'b0;
    bit          m_run = 1'b0;
    bit          m_pf = 1'b0;
    bit          m_acc;
    int          m_t = 0;
    int          slot;
    int          phase;
    logic [31:0] m_ad = '0;
    logic [7:0]  m_ab = '0;
    logic [7:0]  m_adp = '0;
    logic [31:0] m_pd = '0;
    logic [7:0]  m_pb = '0;
    logic [7:0]  m_pdp = '0;
    logic [7:0]  e_an = 8'hFF;
    logic [7:0]  e_sseg = 8'hFF;

    initial forever begin
        @(posedge clk);
        if (reset) begin
            m_run   = 1'b0;
            m_pf    = 1'b0;
            m_t     = 0;
            started = 1'b1;
        end else begin
            m_acc = frame_valid && !m_pf;
            if (!m_run) begin
                if (m_acc) begin
                    m_run = 1'b1;
                    m_ad  = frame_data;
                    m_ab  = frame_blank;
                    m_adp = frame_dp;
                    m_t   = 0;
                end
            end else begin
                if (m_t == FRAME_CYC - 1 && m_pf) begin
                    m_ad  = m_pd;
                    m_ab  = m_pb;
                    m_adp = m_pdp;
                    m_pf  = 1'b0;
                end
                if (m_acc) begin
                    m_pd  = frame_data;
                    m_pb  = frame_blank;
                    m_pdp = frame_dp;
                    m_pf  = 1'b1;
                end
                m_t = (m_t + 1) % FRAME_CYC;
            end
        end
        e_an   = 8'hFF;
        e_sseg = 8'hFF;
        if (m_run) begin
            slot  = m_t / RD;
            phase = m_t % RD;
            if (!m_ab[slot]) begin
                e_an   = ~(8'd1 << slot);
                e_sseg = {~m_adp[slot], SEG_TAB[m_ad[4*slot +: 4]]};
                if (GHOST && phase < 2) e_an = 8'hFF;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (started) begin
            check("ready", frame_ready, !m_pf);
            check("done", frame_done, m_run && !reset && (m_t == FRAME_CYC - 1));
            check("an", an, e_an);
            check("sseg", sseg, e_sseg);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic offer(input logic [31:0] d, input logic [7:0] b, input logic [7:0] p);
        frame_data  = d;
        frame_blank = b;
        frame_dp    = p;
        frame_valid = 1'b1;
    endtask

    int  cnt;
    bit  acc;

    initial begin
        // reset state
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        at_neg();
        check("rst_an", an, 8'hFF);
        check("rst_sseg", sseg, 8'hFF);
        check("rst_ready", frame_ready, 1'b1);

        // first frame loads immediately from IDLE
        offer(32'h0123_4567, 8'h00, 8'h00);
        step(1);
        frame_valid = 1'b0;
        at_neg();
        check("t1_an_c1", an, GHOST ? 8'hFF : 8'hFE);
        check("t1_sseg_c1", sseg, 8'hF8);
        check("t1_model_sseg_c1", e_sseg, 8'hF8);
        step(4);
        at_neg();
        check("t1_an_c5", an, GHOST ? 8'hFF : 8'hFD);
        check("t1_sseg_c5", sseg, 8'h82);
        step(2);
        at_neg();
        check("t1_an_c7", an, 8'hFD);
        check("t1_model_an_c7", e_an, 8'hFD);
        step(24);
        at_neg();
        check("t1_done_c31", frame_done, 1'b0);
        step(1);
        at_neg();
        check("t1_done_c32", frame_done, 1'b1);

        // frame B mid-frame, frame C held until the boundary frees pending
        step(6);
        offer(32'h89AB_CDEF, 8'h00, 8'h00);
        step(1);
        offer(32'h0F1E_2D3C, 8'h00, 8'h0F);
        at_neg();
        check("t2_ready_low", frame_ready, 1'b0);
        cnt = 0;
        while (!frame_ready && cnt < 3 * FRAME_CYC) begin
            at_neg();
            cnt++;
        end
        check("t2_wait_bounded", cnt < 3 * FRAME_CYC, 1'b1);
        check("t2_b_digit0_sseg", sseg, 8'h8E);
        check("t2_b_digit0_an", an, GHOST ? 8'hFF : 8'hFE);
        step(1);
        frame_valid = 1'b0;
        at_neg();
        check("t2_c_taken", frame_ready, 1'b0);

        // blanking and decimal point
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        offer(32'hFFFF_FFFF, 8'b1000_0001, 8'b0000_0010);
        step(1);
        frame_valid = 1'b0;
        at_neg();
        check("t3_slot0_an", an, 8'hFF);
        check("t3_slot0_sseg", sseg, 8'hFF);
        step(4);
        at_neg();
        check("t3_slot1_sseg", sseg, 8'h0E);
        step(2);
        at_neg();
        check("t3_slot1_an", an, 8'hFD);
        step(22);
        at_neg();
        check("t3_slot7_an", an, 8'hFF);
        check("t3_slot7_sseg", sseg, 8'hFF);

        // accept exactly at the boundary with pending empty
        cnt = 0;
        while (!frame_done && cnt < 2 * FRAME_CYC) begin
            at_neg();
            cnt++;
        end
        check("t4_wait_bounded", cnt < 2 * FRAME_CYC, 1'b1);
        offer(32'h1357_9BDF, 8'h00, 8'hFF);
        step(1);
        frame_valid = 1'b0;
        at_neg();
        check("t4_ready_drop", frame_ready, 1'b0);
        check("t4_old_digit0", sseg, 8'hFF);

        // reset while pending is full, mid-slot
        step(10);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        at_neg();
        check("t5_an", an, 8'hFF);
        check("t5_sseg", sseg, 8'hFF);
        check("t5_ready", frame_ready, 1'b1);
        offer(32'hA5A5_5A5A, 8'h00, 8'h00);
        step(1);
        frame_valid = 1'b0;
        at_neg();
        check("t5_new_sseg", sseg, 8'h88);
        check("t5_new_an", an, GHOST ? 8'hFF : 8'hFE);

        // randomized traffic with occasional resets; producer holds until accepted
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            acc = frame_valid && frame_ready;
            @(posedge clk);
            #1;
            reset = ($urandom_range(0, 399) == 0);
            if (acc || !frame_valid) begin
                frame_valid = ($urandom_range(0, 3) == 0);
                frame_data  = $urandom;
                frame_blank = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
                frame_dp    = 8'($urandom);
            end
        end
        reset = 1'b0;
        frame_valid = 1'b0;
        step(2 * FRAME_CYC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
